mlp_accel: RTL and testbench
============================

# mlp_accel

Parametrised two-layer fully-connected inference engine, the generalised successor of the fixed 784-32-10 MNIST accelerator. Pixels stream in over a valid/ready handshake. Weight rows are fetched from external synchronous ROMs, and hidden activations pass through ReLU. Class scores stream out one per beat, and the argmax class index is reported. The block sits between the picoRV32 bus adapter (pixel source, score sink) and the weight ROMs.

## Interface
- DW, 32: data/accumulator width, signed two's complement
- N_IN, 784: input pixels per image
- N_HID, 32: hidden neurons
- N_OUT, 10: output classes
- clk in 1: clock; one clock domain.
- reset in 1: synchronous, active-high.
- start in 1: single-cycle pulse; begins an image. Ignored unless idle.
- in_valid in 1, in_ready out 1, in_data in DW: pixel stream.
- w1_addr out clog2(N_IN): layer-1 ROM row address.
- w1_data in N_HID*DW: row data; lane i at bits [i*DW +: DW]; 1-cycle read latency.
- w2_addr out clog2(N_HID), w2_data in N_OUT*DW: layer-2 ROM, same rules.
- res_valid out 1, res_ready in 1, res_data out DW, res_idx out clog2(N_OUT): score stream.
- class_out out clog2(N_OUT), class_valid out 1: argmax result.
- busy out 1: high whenever the state is not IDLE.
- done out 1: one-cycle pulse after the last score beat is accepted.

## Operation
- States: IDLE, L1, L1_DRAIN, L2, L2_DRAIN, ARGMAX, OUT.
- IDLE, on start: clear acc1[N_HID], acc2[N_OUT] and the pixel counter k. Drop class_valid. Go to L1.
- L1
  - in_ready=1; w1_addr=k.
  - On a handshake, register the pixel and increment k.
  - The cycle after a handshake: acc1[i] += pix_q*w1_lane[i] for all i.
  - Gaps in in_valid stall without corrupting state.
  - After handshake k=N_IN-1, go to L1_DRAIN.
- L1_DRAIN: one cycle, final MAC; in_ready=0. Go to L2 with j=0.
- L2
  - w2_addr=j; j increments every cycle.
  - The cycle after each address: acc2[o] += relu(acc1[j_q])*w2_lane[o].
  - relu(x) = x<0 ? 0 : x.
  - After j=N_HID-1, go to L2_DRAIN (one cycle), then ARGMAX.
- ARGMAX
  - Scans acc2[0..N_OUT-1], one per cycle, with a signed compare.
  - Ties: the lowest index wins.
  - At the end: class_out is set and class_valid=1. class_valid holds until the next start or reset.
- OUT
  - res_valid=1, res_data=acc2[res_idx]; res_idx advances on res_valid&res_ready.
  - After beat N_OUT-1 is accepted: done=1 for one cycle, then IDLE.
- Arithmetic: products and sums are truncated to DW bits (wrap modulo 2^DW). No saturation.
- start while busy: ignored. in_valid outside L1: not accepted.

## Timing
- Reset values (cycle after reset high): state IDLE. Every output is 0: in_ready, res_valid, res_data, res_idx, class_out, class_valid, busy, done, w1_addr, w2_addr. Accumulators are also 0.
- Reset mid-operation aborts immediately. No done pulse is produced, and partial results are discarded.
- Minimum latency from start to first res_valid, with in_valid held high: 1 + N_IN + 1 + N_HID + 1 + N_OUT cycles.
- Output addresses are combinational from the counters. ROM data is consumed exactly one cycle later.
- res_data/res_idx remain stable while res_valid & !res_ready.

## Structure
- Package nn_accel_pkg holds the state enum and the lane-slice helper.
- Sub-module mac_array #(LANES, DW):
  - ports clr, en, a (scalar), b (LANES*DW), acc (LANES*DW).
  - Instantiated twice: LANES=N_HID and LANES=N_OUT.
- ReLU, argmax and the FSM live in mlp_accel.

## Test plan
- N_IN=4, N_HID=2, N_OUT=3.
  - Stimulus: pixels 1,2,3,4; W1 rows {1,0},{0,1},{1,1},{2,-1}; W2 rows {1,0,2},{0,1,-1}.
  - Required: acc1={12,1}; scores {12,1,23}; class_out=2; done once.
- ReLU: W1 lane 1 negated gives acc1={12,-1}. Required: scores {12,0,24}; class 2.
- Backpressure: random in_valid gaps and random res_ready stalls give the same scores as the first case. res_data stays stable during stalls. Exactly 4 input handshakes.
- Tie: all-zero weights. Required: scores all 0; class_out=0.
- Wrap: DW=8, pixel 127 × weight 2 gives acc 254 → -2 (8'hFE), the truncated result.
- Reset asserted during L2. Required: next cycle all outputs 0, no done pulse. A new start then produces correct results.

Source files
------------

// File: rtl/nn_accel_pkg.sv
// Shared types for the MLP inference engine: FSM state encoding and lane slicing.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package nn_accel_pkg;

   typedef enum logic [2:0] {
      IDLE,
      L1,
      L1_DRAIN,
      L2,
      L2_DRAIN,
      ARGMAX,
      OUT
   } state_t;

   // Low bit of lane i in a packed vector of dw-wide lanes.
   function automatic int lane_lo(input int i, input int dw);
      return i * dw;
   endfunction

endpackage

// File: rtl/mlp_accel_mac_array.sv
// LANES parallel multiply-accumulators sharing one scalar operand a.
// Latency: acc reflects a*b one cycle after en; clr zeroes all lanes in one cycle.
// Backpressure: none; en is the only qualifier, acc holds while en is low.
// Ports: clk, reset (sync, active-high), clr, en, a[DW], b[LANES*DW], acc[LANES*DW].
module mac_array
   import nn_accel_pkg::*;
#(
   parameter int LANES = 2,
   parameter int DW    = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clr,
   input  logic                  en,
   input  logic [DW-1:0]         a,
   input  logic [LANES*DW-1:0]   b,
   output logic [LANES*DW-1:0]   acc
);

   // Products and sums are kept at DW bits, so every lane wraps modulo 2^DW;
   // the low DW bits of a product are the same for signed and unsigned operands.
   always_ff @(posedge clk) begin
      if (reset || clr) begin
         acc <= '0;
      end else if (en) begin
         for (int i = 0; i < LANES; i++) begin
            acc[lane_lo(i, DW) +: DW] <= acc[lane_lo(i, DW) +: DW] + a * b[lane_lo(i, DW) +: DW];
         end
      end
   end

endmodule

// File: rtl/mlp_accel.sv
// Two-layer fully-connected inference engine (N_IN -> N_HID ReLU -> N_OUT) with argmax.
// Latency: start to first res_valid is 1+N_IN+1+N_HID+1+N_OUT cycles with in_valid held high.
// Backpressure: in_valid gaps stall layer 1; res_ready low holds res_data/res_idx steady.
// Ports: clk, reset, start | in_valid/in_ready/in_data pixels | w1_addr/w1_data, w2_addr/w2_data
//        weight ROMs (1-cycle read) | res_valid/res_ready/res_data/res_idx scores |
//        class_out/class_valid argmax | busy, done.
module mlp_accel
   import nn_accel_pkg::*;
#(
   parameter int DW    = 32,
   parameter int N_IN  = 784,
   parameter int N_HID = 32,
   parameter int N_OUT = 10
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [DW-1:0]              in_data,
   output logic [$clog2(N_IN)-1:0]    w1_addr,
   input  logic [N_HID*DW-1:0]        w1_data,
   output logic [$clog2(N_HID)-1:0]   w2_addr,
   input  logic [N_OUT*DW-1:0]        w2_data,
   output logic                       res_valid,
   input  logic                       res_ready,
   output logic [DW-1:0]              res_data,
   output logic [$clog2(N_OUT)-1:0]   res_idx,
   output logic [$clog2(N_OUT)-1:0]   class_out,
   output logic                       class_valid,
   output logic                       busy,
   output logic                       done
);

   localparam int KW = $clog2(N_IN);
   localparam int HW = $clog2(N_HID);
   localparam int OW = $clog2(N_OUT);

   state_t              state;
   logic [KW-1:0]       k;
   logic [HW-1:0]       j;
   logic [HW-1:0]       j_q;
   logic [OW-1:0]       scan_idx;
   logic [OW-1:0]       best_idx;
   logic [DW-1:0]       best_val;
   logic [DW-1:0]       pix_q;
   logic                mac1_en;
   logic                mac2_en;
   logic [N_HID*DW-1:0] acc1;
   logic [N_OUT*DW-1:0] acc2;
   logic [DW-1:0]       hid_raw;
   logic [DW-1:0]       hid_act;
   logic [DW-1:0]       cur_score;
   logic                clr;
   logic                in_hs;
   logic                res_hs;
   logic                take;

   assign clr       = (state == IDLE) && start;
   assign in_ready  = (state == L1);
   assign in_hs     = in_valid && in_ready;
   assign res_valid = (state == OUT);
   assign res_hs    = res_valid && res_ready;
   assign busy      = (state != IDLE);

   // ROM addresses come straight from the counters; data is consumed one cycle later.
   assign w1_addr   = (state == L1) ? k : '0;
   assign w2_addr   = (state == L2) ? j : '0;

   assign res_data  = res_valid ? acc2[lane_lo(int'(res_idx), DW) +: DW] : '0;

   // ReLU on the hidden activation addressed in the previous cycle.
   assign hid_raw   = acc1[lane_lo(int'(j_q), DW) +: DW];
   assign hid_act   = hid_raw[DW-1] ? '0 : hid_raw;

   // Strictly-greater signed compare keeps the lowest index on ties.
   assign cur_score = acc2[lane_lo(int'(scan_idx), DW) +: DW];
   assign take      = (scan_idx == '0) || ($signed(cur_score) > $signed(best_val));

   mac_array #(.LANES(N_HID), .DW(DW)) u_mac1 (
      .clk   (clk),
      .reset (reset),
      .clr   (clr),
      .en    (mac1_en),
      .a     (pix_q),
      .b     (w1_data),
      .acc   (acc1)
   );

   mac_array #(.LANES(N_OUT), .DW(DW)) u_mac2 (
      .clk   (clk),
      .reset (reset),
      .clr   (clr),
      .en    (mac2_en),
      .a     (hid_act),
      .b     (w2_data),
      .acc   (acc2)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         k           <= '0;
         j           <= '0;
         j_q         <= '0;
         scan_idx    <= '0;
         best_idx    <= '0;
         best_val    <= '0;
         pix_q       <= '0;
         mac1_en     <= 1'b0;
         mac2_en     <= 1'b0;
         class_out   <= '0;
         class_valid <= 1'b0;
         res_idx     <= '0;
         done        <= 1'b0;
      end else begin
         done    <= 1'b0;
         // MAC enables trail the handshake/address by one cycle to meet ROM data.
         mac1_en <= in_hs;
         mac2_en <= (state == L2);
         j_q     <= j;
         if (in_hs) begin
            pix_q <= in_data;
         end

         case (state)
            IDLE: begin
               if (start) begin
                  k           <= '0;
                  j           <= '0;
                  res_idx     <= '0;
                  class_valid <= 1'b0;
                  state       <= L1;
               end
            end
            L1: begin
               if (in_hs) begin
                  if (k == KW'(N_IN - 1)) begin
                     k     <= '0;
                     state <= L1_DRAIN;
                  end else begin
                     k <= k + 1'b1;
                  end
               end
            end
            L1_DRAIN: begin
               j     <= '0;
               state <= L2;
            end
            L2: begin
               if (j == HW'(N_HID - 1)) begin
                  j     <= '0;
                  state <= L2_DRAIN;
               end else begin
                  j <= j + 1'b1;
               end
            end
            L2_DRAIN: begin
               scan_idx <= '0;
               state    <= ARGMAX;
            end
            ARGMAX: begin
               if (take) begin
                  best_val <= cur_score;
                  best_idx <= scan_idx;
               end
               if (scan_idx == OW'(N_OUT - 1)) begin
                  class_out   <= take ? scan_idx : best_idx;
                  class_valid <= 1'b1;
                  res_idx     <= '0;
                  state       <= OUT;
               end else begin
                  scan_idx <= scan_idx + 1'b1;
               end
            end
            OUT: begin
               if (res_hs) begin
                  if (res_idx == OW'(N_OUT - 1)) begin
                     res_idx <= '0;
                     done    <= 1'b1;
                     state   <= IDLE;
                  end else begin
                     res_idx <= res_idx + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mlp_accel.sv
// Directed bench for mlp_accel: a 4-2-3 network at DW=32 plus a DW=8 wrap instance.
// Latency: checks start-to-first-score latency of 12 cycles for the 4-2-3 shape.
// Backpressure: random in_valid gaps and res_ready stalls, start pulses while busy.
module tb_mlp_accel;

   logic        clk;
   logic        reset;

   // 4-2-3, DW=32 instance
   logic        start;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [1:0]  w1_addr;
   logic [63:0] w1_data;
   logic [0:0]  w2_addr;
   logic [95:0] w2_data;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] res_data;
   logic [1:0]  res_idx;
   logic [1:0]  class_out;
   logic        class_valid;
   logic        busy;
   logic        done;

   // 4-2-3, DW=8 instance
   logic        b_start;
   logic        b_in_valid;
   logic        b_in_ready;
   logic [7:0]  b_in_data;
   logic [1:0]  b_w1_addr;
   logic [15:0] b_w1_data;
   logic [0:0]  b_w2_addr;
   logic [23:0] b_w2_data;
   logic        b_res_valid;
   logic        b_res_ready;
   logic [7:0]  b_res_data;
   logic [1:0]  b_res_idx;
   logic [1:0]  b_class_out;
   logic        b_class_valid;
   logic        b_busy;
   logic        b_done;

   int w1_rom [4][2];
   int w2_rom [2][3];
   int b_w1_rom [4][2];
   int b_w2_rom [2][3];

   int total;
   int bad;
   int hs_cnt;
   int done_cnt;
   int b_done_cnt;

   mlp_accel #(.DW(32), .N_IN(4), .N_HID(2), .N_OUT(3)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .w1_addr     (w1_addr),
      .w1_data     (w1_data),
      .w2_addr     (w2_addr),
      .w2_data     (w2_data),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_data    (res_data),
      .res_idx     (res_idx),
      .class_out   (class_out),
      .class_valid (class_valid),
      .busy        (busy),
      .done        (done)
   );

   mlp_accel #(.DW(8), .N_IN(4), .N_HID(2), .N_OUT(3)) dut8 (
      .clk         (clk),
      .reset       (reset),
      .start       (b_start),
      .in_valid    (b_in_valid),
      .in_ready    (b_in_ready),
      .in_data     (b_in_data),
      .w1_addr     (b_w1_addr),
      .w1_data     (b_w1_data),
      .w2_addr     (b_w2_addr),
      .w2_data     (b_w2_data),
      .res_valid   (b_res_valid),
      .res_ready   (b_res_ready),
      .res_data    (b_res_data),
      .res_idx     (b_res_idx),
      .class_out   (b_class_out),
      .class_valid (b_class_valid),
      .busy        (b_busy),
      .done        (b_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous weight ROMs, one cycle read latency.
   always @(posedge clk) begin
      for (int l = 0; l < 2; l++) w1_data[l*32 +: 32] <= w1_rom[w1_addr][l];
      for (int l = 0; l < 3; l++) w2_data[l*32 +: 32] <= w2_rom[w2_addr][l];
      for (int l = 0; l < 2; l++) b_w1_data[l*8 +: 8] <= 8'(b_w1_rom[b_w1_addr][l]);
      for (int l = 0; l < 3; l++) b_w2_data[l*8 +: 8] <= 8'(b_w2_rom[b_w2_addr][l]);
   end

   always @(posedge clk) begin
      if (in_valid && in_ready) hs_cnt++;
   end

   always @(negedge clk) begin
      if (done) done_cnt++;
      if (b_done) b_done_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0d (0x%08h) want %0d (0x%08h)", tag, $signed(got), got, $signed(want), want);
      end
   endtask

   task automatic load_weights(input int sel);
      case (sel)
         0: begin
            w1_rom = '{'{1, 0}, '{0, 1}, '{1, 1}, '{2, -1}};
            w2_rom = '{'{1, 0, 2}, '{0, 1, -1}};
         end
         1: begin
            w1_rom = '{'{1, 0}, '{0, -1}, '{1, -1}, '{2, 1}};
            w2_rom = '{'{1, 0, 2}, '{0, 1, -1}};
         end
         default: begin
            w1_rom = '{'{0, 0}, '{0, 0}, '{0, 0}, '{0, 0}};
            w2_rom = '{'{0, 0, 0}, '{0, 0, 0}};
         end
      endcase
   endtask

   task automatic chk_idle_outs(input string tag);
      chk({tag, "_in_ready"},    32'(in_ready),    0);
      chk({tag, "_res_valid"},   32'(res_valid),   0);
      chk({tag, "_res_data"},    res_data,         0);
      chk({tag, "_res_idx"},     32'(res_idx),     0);
      chk({tag, "_class_out"},   32'(class_out),   0);
      chk({tag, "_class_valid"}, 32'(class_valid), 0);
      chk({tag, "_busy"},        32'(busy),        0);
      chk({tag, "_done"},        32'(done),        0);
      chk({tag, "_w1_addr"},     32'(w1_addr),     0);
      chk({tag, "_w2_addr"},     32'(w2_addr),     0);
   endtask

   // One image through the DW=32 instance. gap/stall are percentages of idle cycles.
   task automatic run_image(input string tag, input int gap, input int stall,
                            input int e0, input int e1, input int e2, input int ecls,
                            input bit chk_lat);
      int pix [4];
      int want [3];
      int i;
      int cyc;
      int beat;
      int hs0;
      int d0;
      pix  = '{1, 2, 3, 4};
      want = '{e0, e1, e2};
      hs0  = hs_cnt;
      d0   = done_cnt;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc   = 1;
      i     = 0;
      while (i < 4 && cyc < 400) begin
         in_valid = ($urandom_range(0, 99) >= gap);
         in_data  = pix[i];
         if (in_valid && in_ready) i++;
         @(negedge clk);
         cyc++;
      end
      // Junk offered outside L1 must not be taken.
      in_valid = 1'b1;
      in_data  = 32'd999;
      chk({tag, "_clsv_low"}, 32'(class_valid), 0);
      while (!res_valid && cyc < 400) begin
         @(negedge clk);
         cyc++;
      end
      chk({tag, "_res_valid"}, 32'(res_valid), 1);
      if (chk_lat) chk({tag, "_latency"}, cyc, 12);
      chk({tag, "_class"}, 32'(class_out), ecls);
      chk({tag, "_clsv"}, 32'(class_valid), 1);
      beat = 0;
      while (beat < 3 && cyc < 800) begin
         res_ready = ($urandom_range(0, 99) >= stall);
         start     = (beat == 1);
         if (res_valid) begin
            chk({tag, "_idx"}, 32'(res_idx), beat);
            chk({tag, "_score"}, res_data, want[beat]);
            if (res_ready) beat++;
         end
         @(negedge clk);
         cyc++;
      end
      start     = 1'b0;
      res_ready = 1'b0;
      in_valid  = 1'b0;
      chk({tag, "_beats"}, beat, 3);
      repeat (2) @(negedge clk);
      chk({tag, "_done_once"}, done_cnt - d0, 1);
      chk({tag, "_idle"}, 32'(busy), 0);
      chk({tag, "_handshakes"}, hs_cnt - hs0, 4);
   endtask

   initial begin
      int cyc;
      int beat;
      int d0;
      logic [7:0] b_want [3];
      total = 0;
      bad = 0;
      hs_cnt = 0;
      done_cnt = 0;
      b_done_cnt = 0;
      reset = 1'b1;
      start = 1'b0;
      in_valid = 1'b0;
      in_data = '0;
      res_ready = 1'b0;
      b_start = 1'b0;
      b_in_valid = 1'b0;
      b_in_data = '0;
      b_res_ready = 1'b0;
      load_weights(0);
      b_w1_rom = '{'{1, 2}, '{0, 0}, '{0, 0}, '{0, 0}};
      b_w2_rom = '{'{2, 0, 0}, '{0, 5, 0}};

      repeat (2) @(negedge clk);
      chk_idle_outs("rst");
      chk("rst_b_busy", 32'(b_busy), 0);
      chk("rst_b_res_data", 32'(b_res_data), 0);
      reset = 1'b0;

      run_image("basic", 0, 0, 12, 1, 23, 2, 1'b1);
      load_weights(1);
      run_image("relu", 0, 0, 12, 0, 24, 2, 1'b0);
      load_weights(0);
      run_image("bp", 40, 50, 12, 1, 23, 2, 1'b0);
      load_weights(2);
      run_image("tie", 0, 0, 0, 0, 0, 0, 1'b0);

      // Abort in the middle of layer 2.
      load_weights(0);
      @(negedge clk);
      start = 1'b1;
      in_valid = 1'b1;
      in_data = 32'd5;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      chk("abort_w2_addr", 32'(w2_addr), 1);
      chk("abort_busy", 32'(busy), 1);
      d0 = done_cnt;
      reset = 1'b1;
      @(negedge clk);
      chk_idle_outs("abort");
      reset = 1'b0;
      in_valid = 1'b0;
      repeat (20) @(negedge clk);
      chk("abort_no_done", done_cnt - d0, 0);
      run_image("after_rst", 0, 30, 12, 1, 23, 2, 1'b0);

      // DW=8: 127*2 wraps to -2 in layer 2; layer-1 lane 1 wraps negative and ReLU zeroes it.
      b_want = '{8'hFE, 8'h00, 8'h00};
      @(negedge clk);
      b_start = 1'b1;
      b_in_valid = 1'b1;
      b_in_data = 8'd127;
      b_res_ready = 1'b1;
      @(negedge clk);
      b_start = 1'b0;
      @(negedge clk);
      b_in_data = 8'd0;
      cyc = 0;
      while (!b_res_valid && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      chk("wrap_res_valid", 32'(b_res_valid), 1);
      chk("wrap_class", 32'(b_class_out), 1);
      beat = 0;
      while (beat < 3 && cyc < 200) begin
         if (b_res_valid) begin
            chk("wrap_idx", 32'(b_res_idx), beat);
            chk("wrap_score", 32'(b_res_data), 32'(b_want[beat]));
            beat++;
         end
         @(negedge clk);
         cyc++;
      end
      b_in_valid = 1'b0;
      b_res_ready = 1'b0;
      @(negedge clk);
      chk("wrap_beats", beat, 3);
      chk("wrap_done_once", b_done_cnt, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
      $fatal(1, "watchdog");
   end

endmodule
